// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Purpose  : Shared definitions for the UART transmit arbiter: FSM state
//             encoding (one-hot, 3 bits) and the default byte width.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int c_NB_DATA = 8;

    localparam logic [2:0] c_ST_IDLE = 3'b001;
    localparam logic [2:0] c_ST_LOAD = 3'b010;
    localparam logic [2:0] c_ST_SEND = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = c_ST_IDLE,
        ST_LOAD = c_ST_LOAD,
        ST_SEND = c_ST_SEND
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_rr_arbiter
//  Purpose  : Combinational round-robin picker. The request vector is rotated
//             so that index i_ptr lands at bit 0, the lowest set bit is taken,
//             and the one-hot result is rotated back.
//  Ports    : i_req  [N_REQ]   request vector
//             i_ptr  [NB_PTR]  index with highest priority (0..N_REQ-1)
//             o_gnt  [N_REQ]   one-hot grant, 0 when no request
//             o_any            at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter_rr_arbiter #(
    parameter int N_REQ  = 3,
    parameter int NB_PTR = 2
) (
    input  logic [N_REQ-1:0]  i_req,
    input  logic [NB_PTR-1:0] i_ptr,
    output logic [N_REQ-1:0]  o_gnt,
    output logic              o_any
);

    logic [N_REQ-1:0] w_req_rot;
    logic [N_REQ-1:0] w_gnt_rot;
    logic             w_found;

    always_comb begin
        // Rotate right by i_ptr: original index (i_ptr + k) mod N_REQ -> bit k.
        w_req_rot = N_REQ'({i_req, i_req} >> i_ptr);

        w_gnt_rot = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_req_rot[k] && !w_found) begin
                w_gnt_rot[k] = 1'b1;
                w_found      = 1'b1;
            end
        end

        // Rotate left by i_ptr to return to requester numbering.
        o_gnt = N_REQ'(({w_gnt_rot, w_gnt_rot} << i_ptr) >> N_REQ);
        o_any = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one uart_tx among N_REQ byte requesters. Requesters are
//             granted round-robin; a multi-byte frame keeps the grant locked
//             until its last byte or until MAX_FRAME bytes have been sent.
//  Ports    : i_clock, i_reset          clock, synchronous active-high reset
//             i_req_valid/data/last     per-requester byte offer
//             o_req_ready               per-requester accept (in LOAD)
//             o_tx_start, o_tx_data     to uart_tx
//             i_tx_done                 end-of-byte pulse from uart_tx
//             o_grant                   one-hot current owner
//             o_busy                    FSM not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NB_DATA      = c_NB_DATA,
    parameter int N_REQ        = 3,
    parameter int MAX_FRAME    = 16,
    parameter int NB_FRAME_CNT = $clog2(MAX_FRAME + 1)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy
);

    localparam int NB_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [N_REQ-1:0]        r_grant;
    logic                    r_lock;
    logic [NB_FRAME_CNT-1:0] r_frame_cnt;
    logic [NB_PTR-1:0]       r_ptr;
    logic                    r_tx_start;
    logic [NB_DATA-1:0]      r_tx_data;

    logic [N_REQ-1:0]        w_cand;
    logic [N_REQ-1:0]        w_pick;
    logic                    w_any;
    logic [NB_DATA-1:0]      w_sel_data;
    logic                    w_sel_last;
    logic                    w_sel_valid;
    logic [NB_PTR-1:0]       w_owner;
    logic [NB_PTR-1:0]       w_ptr_next;
    logic                    w_release;

    // While a frame is locked only the owner may compete, so the picker can
    // only return the owner (or nothing while the owner is idle).
    assign w_cand = r_lock ? (i_req_valid & r_grant) : i_req_valid;

    uart_tx_arbiter_rr_arbiter #(
        .N_REQ  (N_REQ),
        .NB_PTR (NB_PTR)
    ) u_rr (
        .i_req  (w_cand),
        .i_ptr  (r_ptr),
        .o_gnt  (w_pick),
        .o_any  (w_any)
    );

    // Owner-side view of the request inputs, selected by the one-hot grant.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        w_owner    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_sel_data = i_req_data[k*NB_DATA +: NB_DATA];
                w_sel_last = i_req_last[k];
                w_owner    = NB_PTR'(k);
            end
        end
        w_sel_valid = |(i_req_valid & r_grant);
        w_ptr_next  = (w_owner == NB_PTR'(N_REQ - 1)) ? '0 : w_owner + NB_PTR'(1);
        w_release   = ~r_lock | (r_frame_cnt == NB_FRAME_CNT'(MAX_FRAME));
    end

    // Next-state and combinational outputs
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_req_ready  = r_grant;
                w_state_next = w_sel_valid ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                if (i_tx_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_lock      <= 1'b0;
            r_frame_cnt <= '0;
            r_ptr       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) r_grant <= w_pick;
                end
                ST_LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data   <= w_sel_data;
                        r_tx_start  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + NB_FRAME_CNT'(1);
                        r_lock      <= ~w_sel_last;
                    end else if (!r_lock) begin
                        // Requester withdrew before being served: nobody owns
                        // the transmitter, pointer stays where it was.
                        r_grant <= '0;
                    end
                end
                ST_SEND: begin
                    r_tx_start <= 1'b0;
                    if (i_tx_done && w_release) begin
                        r_lock      <= 1'b0;
                        r_frame_cnt <= '0;
                        r_grant     <= '0;
                        r_ptr       <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_grant    = r_grant;
    assign o_busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter
//             (N_REQ=3, NB_DATA=8, MAX_FRAME=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NB = 8;
    localparam int NR = 3;
    localparam int MF = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    valid;
    logic [NR*NB-1:0] data;
    logic [NR-1:0]    last;
    logic             done;
    logic [NR-1:0]    o_req_ready;
    logic             o_tx_start;
    logic [NB-1:0]    o_tx_data;
    logic [NR-1:0]    o_grant;
    logic             o_busy;

    int checks = 0;
    int errors = 0;
    int w;

    logic [8:0] mem [NR][8];
    int         head [NR];
    int         cnt  [NR];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NB_DATA   (NB),
        .N_REQ     (NR),
        .MAX_FRAME (MF)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (o_req_ready),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_done   (done),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        mem[k][cnt[k]] = {l, d};
        cnt[k]++;
    endtask

    task automatic refresh(input int k);
        if (head[k] < cnt[k]) begin
            valid[k]           = 1'b1;
            data[k*NB +: NB]   = mem[k][head[k]][7:0];
            last[k]            = mem[k][head[k]][8];
        end else begin
            valid[k] = 1'b0;
            last[k]  = 1'b0;
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NR; k++) begin
            head[k] = 0;
            cnt[k]  = 0;
        end
        valid = '0;
        last  = '0;
        data  = '0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One byte from requester k: wait for LOAD, check owner, check start and
    // data through SEND, pulse done, check grant afterwards.
    task automatic xfer(input int k, input logic rel, output int waits);
        logic [7:0]    exp_d;
        logic [NR-1:0] onehot;
        exp_d  = mem[k][head[k]][7:0];
        onehot = NR'(1) << k;
        waits  = 0;
        @(negedge clk);
        while (o_req_ready == '0 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("ready_owner", o_req_ready, onehot);
        chk("grant_load", o_grant, onehot);
        @(posedge clk);
        #1;
        head[k]++;
        refresh(k);
        @(negedge clk);
        chk("start_pulse", o_tx_start, 1);
        chk("tx_data", o_tx_data, exp_d);
        chk("ready_in_send", o_req_ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("start_low", o_tx_start, 0);
            chk("data_hold", o_tx_data, exp_d);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("grant_after", o_grant, rel ? NR'(0) : onehot);
        chk("busy_after", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        done = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_data",  o_tx_data, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy",  o_busy, 0);
        rst = 1'b0;

        // 1: single byte from req1, ready one cycle after valid, start next
        push(1, 8'hA5, 1'b1);
        refresh(1);
        xfer(1, 1'b1, w);
        chk("t1_latency", w, 0);
        // pointer now 2: req2 beats req0
        push(0, 8'h01, 1'b1);
        push(2, 8'h02, 1'b1);
        refresh(0);
        refresh(2);
        xfer(2, 1'b1, w);
        xfer(0, 1'b1, w);

        // 2: all three valid, order 0,1,2,0
        do_reset();
        push(0, 8'h10, 1'b1);
        push(0, 8'h40, 1'b1);
        push(1, 8'h20, 1'b1);
        push(2, 8'h30, 1'b1);
        refresh(0);
        refresh(1);
        refresh(2);
        xfer(0, 1'b1, w);
        xfer(1, 1'b1, w);
        xfer(2, 1'b1, w);
        xfer(0, 1'b1, w);

        // 3: locked 3-byte frame from req0 while req2 waits
        do_reset();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        push(2, 8'h99, 1'b1);
        refresh(0);
        refresh(2);
        xfer(0, 1'b0, w);
        xfer(0, 1'b0, w);
        xfer(0, 1'b1, w);
        xfer(2, 1'b1, w);

        // 4: req0 never marks last, forced release after 4 bytes
        do_reset();
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b0);
        push(0, 8'hA4, 1'b0);
        push(0, 8'hA5, 1'b0);
        push(1, 8'hB1, 1'b1);
        refresh(0);
        refresh(1);
        xfer(0, 1'b0, w);
        xfer(0, 1'b0, w);
        xfer(0, 1'b0, w);
        xfer(0, 1'b1, w);
        xfer(1, 1'b1, w);

        // 5: req2 drops valid in LOAD (pointer at 1 beforehand)
        do_reset();
        push(0, 8'hC0, 1'b1);
        refresh(0);
        xfer(0, 1'b1, w);
        push(2, 8'h5C, 1'b1);
        refresh(2);
        @(negedge clk);
        chk("t5_load_ready", o_req_ready, 3'b100);
        valid[2] = 1'b0;
        @(negedge clk);
        chk("t5_no_start", o_tx_start, 0);
        chk("t5_idle", o_busy, 0);
        chk("t5_grant", o_grant, 0);
        @(negedge clk);
        chk("t5_stay_idle", o_busy, 0);
        refresh(2);
        push(0, 8'hC1, 1'b1);
        push(1, 8'hD1, 1'b1);
        refresh(0);
        refresh(1);
        xfer(1, 1'b1, w);
        xfer(2, 1'b1, w);
        xfer(0, 1'b1, w);

        // 6: reset in SEND mid-frame, then stray done in IDLE
        do_reset();
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b1);
        refresh(0);
        @(negedge clk);
        chk("t6_load", o_req_ready, 3'b001);
        @(posedge clk);
        #1;
        head[0]++;
        refresh(0);
        @(negedge clk);
        chk("t6_send_start", o_tx_start, 1);
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        chk("t6_rst_ready", o_req_ready, 0);
        chk("t6_rst_start", o_tx_start, 0);
        chk("t6_rst_data",  o_tx_data, 0);
        chk("t6_rst_grant", o_grant, 0);
        chk("t6_rst_busy",  o_busy, 0);
        rst  = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t6_stray_busy",  o_busy, 0);
        chk("t6_stray_grant", o_grant, 0);
        chk("t6_stray_start", o_tx_start, 0);
        @(negedge clk);
        chk("t6_stray_idle", o_busy, 0);
        push(1, 8'hF1, 1'b1);
        push(2, 8'hF2, 1'b1);
        refresh(1);
        refresh(2);
        xfer(1, 1'b1, w);
        xfer(2, 1'b1, w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
